transport_receive: RTL and testbench
====================================

Name: transport_receive

Overview:
Receive-side transport layer. Consumes the byte stream produced by the transport sender, delivered one byte per strobe, and parses fixed-size packets. It recovers 16-bit control words and audio samples and presents them to the application layer as tagged, single-cycle-valid words. It also flags framing errors and stalled streams.

Parameters:
PACKET_SIZE, 16, packet length in bytes; must be even and >= 4
TIMEOUT, 64, idle cycles tolerated mid-packet before abort; must be >= 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
byte_in  in  8  packet byte, sampled only when byte_valid=1
byte_valid  in  1  one byte presented this cycle (driven by sender's sending flag)
cmd_out  out  2  tag of data_out: 2'b01 control, 2'b10 audio, 2'b00 none
data_out  out  16  recovered word
data_valid  out  1  one-cycle pulse; data_out/cmd_out valid while high
pkt_done  out  1  one-cycle pulse on the last byte of a well-formed packet
bad_header  out  1  one-cycle pulse on an unrecognised header byte
bad_trailer  out  1  one-cycle pulse on a wrong audio trailer byte
timeout_err  out  1  one-cycle pulse when a packet is aborted for inactivity
pkt_count  out  8  count of well-formed packets, wraps 255->0

Behaviour:
- Clock and reset: reset is synchronous and active-high; clk is the only clock.
- Reset values: all outputs 0; FSM in IDLE; byte counter 0; gap counter 0. Reset mid-packet discards the partial packet with no pulses.
- All outputs are registered. For the byte sampled at edge N, any resulting pulse is high for exactly the cycle following edge N.
- A byte is consumed only when byte_valid=1. No backpressure exists; the consumer must accept each data_valid pulse.
- Packet formats (byte 0 first, words MSB first):
  - Control: 0x40, hi, lo, then PACKET_SIZE-3 pad bytes. Pad content is ignored.
  - Audio: 0x81, then S=(PACKET_SIZE-2)/2 samples as hi,lo pairs, then trailer 0xFF.
- FSM states:
  - IDLE:
    - 0x40 -> CTRL_HI.
    - 0x81 -> AUD_HI.
    - Any other byte -> pulse bad_header, enter DISCARD with remaining=PACKET_SIZE-1.
  - CTRL_HI: latch hi -> CTRL_LO.
  - CTRL_LO: emit data_out={hi,byte}, cmd_out=01, data_valid. Then enter CTRL_PAD with remaining=PACKET_SIZE-3.
    - If PACKET_SIZE=4, the single pad byte is handled in CTRL_PAD as normal.
  - CTRL_PAD: decrement on each byte. On the last pad byte, pulse pkt_done, increment pkt_count, go to IDLE.
  - AUD_HI: latch hi -> AUD_LO.
  - AUD_LO: emit data_out={hi,byte}, cmd_out=10, data_valid; increment the sample counter.
    - Counter < S -> AUD_HI.
    - Counter = S -> AUD_TRAIL.
  - AUD_TRAIL:
    - 0xFF -> pulse pkt_done, increment pkt_count.
    - Other -> pulse bad_trailer; pkt_count unchanged; samples already emitted stand.
    - Either case -> IDLE.
  - DISCARD: decrement on each byte; at 0 -> IDLE. No outputs.
- cmd_out and data_out hold their last value between pulses.
- Timeout:
  - The gap counter increments on each cycle with byte_valid=0 while the state is not IDLE.
  - It clears on any valid byte, and whenever the state is IDLE.
  - When the counter reaches TIMEOUT: pulse timeout_err, go to IDLE, clear all counters.
  - No pkt_done is issued for the aborted packet; words already emitted stand.
  - A valid byte arriving in the same cycle as the terminal count is consumed normally, and no timeout occurs.
- Simultaneous events: at most one of pkt_done/bad_header/bad_trailer/timeout_err is high in any cycle. data_valid never coincides with bad_header.
- pkt_count wraps modulo 256.

Test Plan:
1. Control packet: 0x40,0x12,0x34 + 13x0x00 on consecutive cycles.
   -> One data_valid with cmd_out=01, data_out=0x1234, the cycle after byte 2.
   -> pkt_done after byte 15; pkt_count=1.
2. Audio packet: 0x81, samples 0x0001..0x0007, then 0xFF, with byte_valid toggling every other cycle.
   -> 7 data_valid pulses, cmd_out=10, data_out 0x0001..0x0007 in order.
   -> pkt_done on trailer; pkt_count increments.
3. Bad header: 0x55 + 15 bytes containing 0x40, then a good control packet carrying 0xBEEF.
   -> bad_header once; no data_valid during the discarded 15 bytes.
   -> Then data_out=0xBEEF, pkt_count increments.
4. Bad trailer: audio packet ending in 0x00.
   -> 7 samples delivered, bad_trailer pulse, no pkt_done, pkt_count unchanged.
5. Timeout: 0x81,0xAA,0xBB,0xCC,0xDD, then byte_valid=0 for 64 cycles.
   -> data_valid for 0xAABB and 0xCCDD; timeout_err on the 64th idle cycle.
   -> A following control packet parses correctly.
   -> With only 63 idle cycles, no timeout occurs and the packet resumes.
6. Reset after byte 3 of an audio packet, then a full control packet.
   -> All outputs 0 after reset; control packet decoded; pkt_count=1.
   -> Also: 256 good packets -> pkt_count wraps to 0.

Source files
------------

// File: rtl/transport_receive.sv
// Parses fixed-size control/audio packets from a byte stream into tagged 16-bit words.
// All outputs registered: one cycle after the sampled byte; no backpressure, every data_valid must be taken.
module transport_receive #(
  parameter int PACKET_SIZE = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [1:0]  cmd_out,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        pkt_done,
  output logic        bad_header,
  output logic        bad_trailer,
  output logic        timeout_err,
  output logic [7:0]  pkt_count
);

  localparam int CW = $clog2(PACKET_SIZE + 1);
  localparam int GW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DISCARD_LEN = CW'(PACKET_SIZE - 1);
  localparam logic [CW-1:0] PAD_LEN     = CW'(PACKET_SIZE - 3);
  localparam logic [CW-1:0] NUM_SAMPLES = CW'((PACKET_SIZE - 2) / 2);
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(TIMEOUT - 1);

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h81;
  localparam logic [7:0] TRAILER   = 8'hFF;

  localparam logic [1:0] TAG_CTRL  = 2'b01;
  localparam logic [1:0] TAG_AUDIO = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HI,
    CTRL_LO,
    CTRL_PAD,
    AUD_HI,
    AUD_LO,
    AUD_TRAIL,
    DISCARD
  } stateType;

  stateType      state, stateNext;
  logic [CW-1:0] remaining, remainingNext;
  logic [CW-1:0] sampleCnt, sampleCntNext;
  logic [GW-1:0] gapCnt, gapCntNext;
  logic [7:0]    hiByte, hiByteNext;

  logic [1:0]    cmdNext;
  logic [15:0]   dataNext;
  logic          dataValidNext;
  logic          pktDoneNext;
  logic          badHeaderNext;
  logic          badTrailerNext;
  logic          timeoutNext;
  logic [7:0]    pktCountNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      sampleCnt   <= '0;
      gapCnt      <= '0;
      hiByte      <= '0;
      cmd_out     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      pkt_done    <= 1'b0;
      bad_header  <= 1'b0;
      bad_trailer <= 1'b0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      state       <= stateNext;
      remaining   <= remainingNext;
      sampleCnt   <= sampleCntNext;
      gapCnt      <= gapCntNext;
      hiByte      <= hiByteNext;
      cmd_out     <= cmdNext;
      data_out    <= dataNext;
      data_valid  <= dataValidNext;
      pkt_done    <= pktDoneNext;
      bad_header  <= badHeaderNext;
      bad_trailer <= badTrailerNext;
      timeout_err <= timeoutNext;
      pkt_count   <= pktCountNext;
    end
  end

  always_comb begin
    stateNext      = state;
    remainingNext  = remaining;
    sampleCntNext  = sampleCnt;
    gapCntNext     = gapCnt;
    hiByteNext     = hiByte;
    cmdNext        = cmd_out;
    dataNext       = data_out;
    dataValidNext  = 1'b0;
    pktDoneNext    = 1'b0;
    badHeaderNext  = 1'b0;
    badTrailerNext = 1'b0;
    timeoutNext    = 1'b0;
    pktCountNext   = pkt_count;

    if (byte_valid) begin
      // A byte on the terminal idle cycle wins over the timeout.
      gapCntNext = '0;
      case (state)
        IDLE: begin
          sampleCntNext = '0;
          if (byte_in == HDR_CTRL) begin
            stateNext = CTRL_HI;
          end else if (byte_in == HDR_AUDIO) begin
            stateNext = AUD_HI;
          end else begin
            badHeaderNext = 1'b1;
            remainingNext = DISCARD_LEN;
            stateNext     = DISCARD;
          end
        end
        CTRL_HI: begin
          hiByteNext = byte_in;
          stateNext  = CTRL_LO;
        end
        CTRL_LO: begin
          dataNext      = {hiByte, byte_in};
          cmdNext       = TAG_CTRL;
          dataValidNext = 1'b1;
          remainingNext = PAD_LEN;
          stateNext     = CTRL_PAD;
        end
        CTRL_PAD: begin
          if (remaining <= ONE) begin
            pktDoneNext   = 1'b1;
            pktCountNext  = pkt_count + 8'd1;
            remainingNext = '0;
            stateNext     = IDLE;
          end else begin
            remainingNext = remaining - ONE;
          end
        end
        AUD_HI: begin
          hiByteNext = byte_in;
          stateNext  = AUD_LO;
        end
        AUD_LO: begin
          dataNext      = {hiByte, byte_in};
          cmdNext       = TAG_AUDIO;
          dataValidNext = 1'b1;
          sampleCntNext = sampleCnt + ONE;
          stateNext     = (sampleCnt + ONE == NUM_SAMPLES) ? AUD_TRAIL : AUD_HI;
        end
        AUD_TRAIL: begin
          if (byte_in == TRAILER) begin
            pktDoneNext  = 1'b1;
            pktCountNext = pkt_count + 8'd1;
          end else begin
            badTrailerNext = 1'b1;
          end
          sampleCntNext = '0;
          stateNext     = IDLE;
        end
        DISCARD: begin
          if (remaining <= ONE) begin
            remainingNext = '0;
            stateNext     = IDLE;
          end else begin
            remainingNext = remaining - ONE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (gapCnt == GAP_LAST) begin
        timeoutNext   = 1'b1;
        stateNext     = IDLE;
        remainingNext = '0;
        sampleCntNext = '0;
        gapCntNext    = '0;
      end else begin
        gapCntNext = gapCnt + GW'(1);
      end
    end else begin
      gapCntNext = '0;
    end
  end

endmodule

// File: tb/tb_transport_receive.sv
// Directed bench for transport_receive with default parameters (16-byte packets, 64-cycle timeout).
module tb_transport_receive;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [1:0]  cmd_out;
  logic [15:0] data_out;
  logic        data_valid;
  logic        pkt_done;
  logic        bad_header;
  logic        bad_trailer;
  logic        timeout_err;
  logic [7:0]  pkt_count;

  transport_receive #(.PACKET_SIZE(16), .TIMEOUT(64)) dut (
    .clk(clk),
    .reset(reset),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .cmd_out(cmd_out),
    .data_out(data_out),
    .data_valid(data_valid),
    .pkt_done(pkt_done),
    .bad_header(bad_header),
    .bad_trailer(bad_trailer),
    .timeout_err(timeout_err),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] words[$];
  logic [1:0]  tags[$];
  int nDone, nBadHdr, nBadTrl, nTimeout;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    words.delete();
    tags.delete();
    nDone = 0;
    nBadHdr = 0;
    nBadTrl = 0;
    nTimeout = 0;
  endtask

  // Drive one cycle, then sample the registered outputs 1ns after the edge.
  task automatic step(input logic v, input logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    @(posedge clk);
    #1;
    if (data_valid) begin
      words.push_back(data_out);
      tags.push_back(cmd_out);
    end
    nDone    = nDone + int'(pkt_done);
    nBadHdr  = nBadHdr + int'(bad_header);
    nBadTrl  = nBadTrl + int'(bad_trailer);
    nTimeout = nTimeout + int'(timeout_err);
  endtask

  task automatic sendCtrl(input logic [7:0] hi, input logic [7:0] lo);
    step(1'b1, 8'h40);
    step(1'b1, hi);
    step(1'b1, lo);
    for (int i = 0; i < 13; i++) step(1'b1, 8'h00);
  endtask

  task automatic doReset();
    reset = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkVal({pfx, "_cmd"}, 32'(cmd_out), 32'h0);
    checkVal({pfx, "_data"}, 32'(data_out), 32'h0);
    checkVal({pfx, "_flags"}, 32'({data_valid, pkt_done, bad_header, bad_trailer, timeout_err}), 32'h0);
    checkVal({pfx, "_count"}, 32'(pkt_count), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    doReset();
    checkIdleOutputs("rst");

    // 1: control packet 0x1234
    clearLog();
    step(1'b1, 8'h40);
    step(1'b1, 8'h12);
    checkVal("c1_dv_early", 32'(data_valid), 32'h0);
    step(1'b1, 8'h34);
    checkVal("c1_dv", 32'(data_valid), 32'h1);
    checkVal("c1_cmd", 32'(cmd_out), 32'h1);
    checkVal("c1_data", 32'(data_out), 32'h1234);
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 8'h00);
      if (i == 11) checkVal("c1_done_early", 32'(pkt_done), 32'h0);
    end
    checkVal("c1_done", 32'(pkt_done), 32'h1);
    checkVal("c1_count", 32'(pkt_count), 32'h1);
    step(1'b0, 8'h00);
    checkVal("c1_done_pulse", 32'(pkt_done), 32'h0);
    checkVal("c1_hold_data", 32'(data_out), 32'h1234);
    checkVal("c1_nwords", 32'(words.size()), 32'h1);

    // 2: audio with byte_valid toggling
    clearLog();
    step(1'b1, 8'h81);
    for (int s = 1; s <= 7; s++) begin
      step(1'b0, 8'h00);
      step(1'b1, 8'h00);
      step(1'b0, 8'h00);
      step(1'b1, 8'(s));
    end
    step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    checkVal("a2_done", 32'(pkt_done), 32'h1);
    checkVal("a2_count", 32'(pkt_count), 32'h2);
    checkVal("a2_nwords", 32'(words.size()), 32'h7);
    for (int s = 0; s < 7 && s < words.size(); s++) begin
      checkVal("a2_word", 32'(words[s]), 32'(s + 1));
      checkVal("a2_tag", 32'(tags[s]), 32'h2);
    end

    // 3: bad header, payload with embedded 0x40, then control 0xBEEF
    clearLog();
    step(1'b1, 8'h55);
    checkVal("b3_badhdr", 32'(bad_header), 32'h1);
    checkVal("b3_dv", 32'(data_valid), 32'h0);
    for (int i = 0; i < 15; i++) step(1'b1, (i % 3 == 0) ? 8'h40 : 8'(i));
    checkVal("b3_nwords_discard", 32'(words.size()), 32'h0);
    checkVal("b3_nbadhdr", 32'(nBadHdr), 32'h1);
    sendCtrl(8'hBE, 8'hEF);
    checkVal("b3_nwords", 32'(words.size()), 32'h1);
    if (words.size() > 0) checkVal("b3_word", 32'(words[0]), 32'hBEEF);
    checkVal("b3_count", 32'(pkt_count), 32'h3);
    checkVal("b3_ndone", 32'(nDone), 32'h1);

    // 4: audio with bad trailer
    clearLog();
    step(1'b1, 8'h81);
    for (int s = 1; s <= 7; s++) begin
      step(1'b1, 8'hA0);
      step(1'b1, 8'(s));
    end
    step(1'b1, 8'h00);
    checkVal("t4_badtrl", 32'(bad_trailer), 32'h1);
    checkVal("t4_done", 32'(pkt_done), 32'h0);
    checkVal("t4_count", 32'(pkt_count), 32'h3);
    checkVal("t4_nwords", 32'(words.size()), 32'h7);
    if (words.size() == 7) checkVal("t4_last", 32'(words[6]), 32'hA007);

    // 5: timeout after two samples
    clearLog();
    step(1'b1, 8'h81);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b1, 8'hCC);
    step(1'b1, 8'hDD);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00);
    checkVal("o5_no_to_63", 32'(nTimeout), 32'h0);
    step(1'b0, 8'h00);
    checkVal("o5_to", 32'(timeout_err), 32'h1);
    checkVal("o5_nwords", 32'(words.size()), 32'h2);
    if (words.size() == 2) begin
      checkVal("o5_w0", 32'(words[0]), 32'hAABB);
      checkVal("o5_w1", 32'(words[1]), 32'hCCDD);
    end
    step(1'b0, 8'h00);
    checkVal("o5_to_pulse", 32'(timeout_err), 32'h0);
    sendCtrl(8'h5A, 8'hA5);
    checkVal("o5_ctrl", 32'(data_out), 32'h5AA5);
    checkVal("o5_count", 32'(pkt_count), 32'h4);
    checkVal("o5_ndone", 32'(nDone), 32'h1);

    // 5b: 63 idle cycles then resume
    clearLog();
    step(1'b1, 8'h81);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00);
    for (int s = 3; s <= 14; s++) step(1'b1, 8'(s));
    step(1'b1, 8'hFF);
    checkVal("r5_nto", 32'(nTimeout), 32'h0);
    checkVal("r5_done", 32'(pkt_done), 32'h1);
    checkVal("r5_count", 32'(pkt_count), 32'h5);
    checkVal("r5_nwords", 32'(words.size()), 32'h7);
    if (words.size() == 7) checkVal("r5_w6", 32'(words[6]), 32'h0D0E);

    // 6: reset mid audio packet
    clearLog();
    step(1'b1, 8'h81);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    doReset();
    checkIdleOutputs("r6");
    sendCtrl(8'hC0, 8'hDE);
    checkVal("r6_data", 32'(data_out), 32'hC0DE);
    checkVal("r6_count", 32'(pkt_count), 32'h1);
    checkVal("r6_nbad", 32'(nBadHdr + nBadTrl + nTimeout), 32'h0);

    for (int p = 0; p < 254; p++) sendCtrl(8'(p), 8'h00);
    checkVal("w6_count255", 32'(pkt_count), 32'hFF);
    sendCtrl(8'h77, 8'h88);
    checkVal("w6_wrap", 32'(pkt_count), 32'h0);
    checkVal("w6_done", 32'(pkt_done), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
